// File: rtl/spu_sm_xsub_if.sv
// -----------------------------------------------------------------------------
// spu_sm_xsub_if
// Purpose : carries the score input stream and the distance output stream of
//           the softmax subtract stage.
// Signals : in_valid/in_ready/in_data    - int8 x8 score beats into the stage
//           out_valid/out_ready/out_data - uint8 x8 distance beats out
//           out_last                     - final beat of a row
// Modports: slave  - the subtract stage (consumes in_*, produces out_*)
//           master - the surrounding logic (produces in_*, consumes out_*)
// -----------------------------------------------------------------------------
interface spu_sm_xsub_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/spu_sm_xsub.sv
// -----------------------------------------------------------------------------
// spu_sm_xsub
// Purpose : second pass of the softmax datapath. Buffers one row of int8
//           scores while feeding every beat to the external running-max unit,
//           then replays the row as per-lane distances (row_max - x).
// Ports   : core_clk, rst_n       - clock, async active-low reset
//           start, row_len        - row start pulse and length in beats (IDLE)
//           bus                   - score/distance streams (slave modport)
//           comp_en, comp_rst     - fold beat / restore running max
//           max_lane_data         - lanes presented to the max unit
//           max_comp              - running max returned by the max unit
//           busy, err             - not-idle flag, rejected-start pulse
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; bad row_len gives a one-cycle err pulse
// LOAD   | accepting beats into the buffer and into the max unit
// SETTLE | one cycle for the max unit register to hold the row max
// DRAIN  | replaying buffered beats as max_comp - x through one output reg
// CLEAR  | one-cycle comp_rst to the max unit, then back to IDLE
// -----------------------------------------------------------------------------
module spu_sm_xsub #(
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic               core_clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   row_len,
    spu_sm_xsub_if.slave       bus,
    output logic               comp_en,
    output logic               comp_rst,
    output logic [63:0]        max_lane_data,
    input  logic [7:0]         max_comp,
    output logic               busy,
    output logic               err
);
    localparam int ADDR_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_DRAIN,
        S_CLEAR
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic [63:0]      row_buf [MAX_BEATS];

    logic        out_valid_q;
    logic [63:0] out_data_q;
    logic        out_last_q;
    logic        err_q;
    logic        in_ready_c;

    logic        len_ok;
    logic        start_ok;
    logic        in_fire;
    logic        out_fire;
    logic        load_beat;
    logic [63:0] rd_word;
    logic [63:0] sub_data;

    assign len_ok   = (row_len != '0) && (row_len <= CNT_W'(MAX_BEATS));
    assign start_ok = (state == S_IDLE) && start && len_ok;
    assign in_fire  = (state == S_LOAD) && bus.in_valid;
    assign out_fire = out_valid_q && bus.out_ready;

    // A new beat enters the output register when beats remain and the
    // register is empty or being emptied this cycle.
    assign load_beat = (state == S_DRAIN) && (rd_cnt != len_q) &&
                       (!out_valid_q || bus.out_ready);

    assign rd_word = row_buf[rd_cnt[ADDR_W-1:0]];

    // max_comp >= every lane, so the 9-bit signed difference lies in 0..255
    // and its low 8 bits are exactly the modulo-256 8-bit subtraction.
    always_comb begin
        sub_data = '0;
        for (int k = 0; k < 8; k++) begin
            sub_data[8*k +: 8] = max_comp - rd_word[8*k +: 8];
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready_c = 1'b0;
        comp_en    = 1'b0;
        comp_rst   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) next_state = S_LOAD;
            end
            S_LOAD: begin
                in_ready_c = 1'b1;
                comp_en    = bus.in_valid;
                if (bus.in_valid && (wr_cnt == len_q - CNT_W'(1))) next_state = S_SETTLE;
            end
            S_SETTLE: begin
                next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_fire && out_last_q) next_state = S_CLEAR;
            end
            S_CLEAR: begin
                comp_rst   = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= (state == S_IDLE) && start && !len_ok;
            if (start_ok) begin
                len_q  <= row_len;
                wr_cnt <= '0;
                rd_cnt <= '0;
            end
            if (in_fire) wr_cnt <= wr_cnt + CNT_W'(1);
            if (load_beat) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sub_data;
                out_last_q  <= (rd_cnt == len_q - CNT_W'(1));
                rd_cnt      <= rd_cnt + CNT_W'(1);
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    // Buffer contents need no reset: a row is only read after being written.
    always_ff @(posedge core_clk) begin
        if (in_fire) row_buf[wr_cnt[ADDR_W-1:0]] <= bus.in_data;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign max_lane_data = bus.in_data;
    assign busy          = (state != S_IDLE);
    assign err           = err_q;
endmodule

// File: tb/tb_spu_sm_xsub.sv
// -----------------------------------------------------------------------------
// tb_spu_sm_xsub
// Purpose : directed bench for spu_sm_xsub. Includes a small behavioural
//           running-max unit that answers comp_en/comp_rst with max_comp.
// -----------------------------------------------------------------------------
module tb_spu_sm_xsub;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  row_len;
    logic        comp_en;
    logic        comp_rst;
    logic [63:0] max_lane_data;
    logic [7:0]  max_comp;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    logic [63:0] row  [16];
    logic [63:0] expv [16];

    spu_sm_xsub_if #(.DATA_W(64)) bus ();

    spu_sm_xsub #(.MAX_BEATS(16), .CNT_W(5)) dut (
        .core_clk      (clk),
        .rst_n         (rst_n),
        .start         (start),
        .row_len       (row_len),
        .bus           (bus),
        .comp_en       (comp_en),
        .comp_rst      (comp_rst),
        .max_lane_data (max_lane_data),
        .max_comp      (max_comp),
        .busy          (busy),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running-max unit: idles at -127; the first folded beat after a
    // reset/clear loads directly so an all -128 row yields a -128 max.
    logic signed [7:0] mx;
    logic              mx_first;

    function automatic logic signed [7:0] beat_max(input logic [63:0] d);
        logic signed [7:0] m;
        m = $signed(d[7:0]);
        for (int k = 1; k < 8; k++)
            if ($signed(d[8*k +: 8]) > m) m = $signed(d[8*k +: 8]);
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mx       <= -8'sd127;
            mx_first <= 1'b1;
        end else if (comp_rst) begin
            mx       <= -8'sd127;
            mx_first <= 1'b1;
        end else if (comp_en) begin
            if (mx_first || (beat_max(max_lane_data) > mx)) mx <= beat_max(max_lane_data);
            mx_first <= 1'b0;
        end
    end
    assign max_comp = mx;

    function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3,
                                       input int l4, input int l5, input int l6, input int l7);
        return {l7[7:0], l6[7:0], l5[7:0], l4[7:0], l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
    endfunction

    function automatic logic [63:0] uni(input int v);
        return {8{v[7:0]}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start   = 1'b1;
        row_len = n[4:0];
        tick();
        start   = 1'b0;
        chk("busy_load", {63'd0, busy}, 64'd1);
    endtask

    // Feeds row[0..n-1] one per cycle; returns in the SETTLE cycle.
    task automatic send_row(input int n);
        for (int j = 0; j < n; j++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = row[j];
            #1;
            chk("in_ready_load", {63'd0, bus.in_ready}, 64'd1);
            chk("comp_en_load",  {63'd0, comp_en}, 64'd1);
            chk("lane_pass",     max_lane_data, row[j]);
            tick();
        end
        #1;
        chk("in_ready_settle", {63'd0, bus.in_ready}, 64'd0);
        chk("comp_en_settle",  {63'd0, comp_en}, 64'd0);
        bus.in_valid = 1'b0;
    endtask

    // Drains with out_ready held high; optionally holds start during DRAIN.
    task automatic drain_all(input int n, input bit hold_start);
        bus.out_ready = 1'b1;
        tick();
        chk("valid_drain_entry", {63'd0, bus.out_valid}, 64'd0);
        tick();
        for (int j = 0; j < n; j++) begin
            chk("out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("out_data",  bus.out_data, expv[j]);
            chk("out_last",  {63'd0, bus.out_last}, {63'd0, j == n - 1});
            chk("err_drain", {63'd0, err}, 64'd0);
            start   = hold_start && (j != n - 1);
            row_len = 5'd0;
            tick();
        end
        chk("valid_clear",    {63'd0, bus.out_valid}, 64'd0);
        chk("comp_rst_clear", {63'd0, comp_rst}, 64'd1);
        chk("comp_en_clear",  {63'd0, comp_en}, 64'd0);
        chk("err_clear",      {63'd0, err}, 64'd0);
        chk("busy_clear",     {63'd0, busy}, 64'd1);
        tick();
        chk("comp_rst_idle", {63'd0, comp_rst}, 64'd0);
        chk("busy_idle",     {63'd0, busy}, 64'd0);
    endtask

    task automatic one_beat_row();
        row[0]  = pk(5, -3, 0, 7, -128, 1, 2, 3);
        expv[0] = pk(2, 10, 7, 0, 135, 6, 5, 4);
        do_start(1);
        send_row(1);
        drain_all(1, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},  {63'd0, bus.in_ready}, 64'd0);
        chk({tag, "_comp_en"},   {63'd0, comp_en}, 64'd0);
        chk({tag, "_comp_rst"},  {63'd0, comp_rst}, 64'd0);
        chk({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
        chk({tag, "_out_data"},  bus.out_data, 64'd0);
        chk({tag, "_out_last"},  {63'd0, bus.out_last}, 64'd0);
        chk({tag, "_busy"},      {63'd0, busy}, 64'd0);
        chk({tag, "_err"},       {63'd0, err}, 64'd0);
    endtask

    int hs;
    logic [3:0] ready_seq [6];

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        row_len       = 5'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 64'd0;
        bus.out_ready = 1'b0;
        #1;
        check_reset_values("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1-beat row
        one_beat_row();

        // 4-beat row, beat i lanes = 10*i-20; start held (row_len=0) in DRAIN
        for (int i = 0; i < 4; i++) row[i] = uni(10 * i - 20);
        expv[0] = uni(30); expv[1] = uni(20); expv[2] = uni(10); expv[3] = uni(0);
        do_start(4);
        send_row(4);
        drain_all(4, 1'b1);

        // all -128 row
        row[0] = uni(-128); row[1] = uni(-128);
        expv[0] = 64'd0; expv[1] = 64'd0;
        do_start(2);
        send_row(2);
        drain_all(2, 1'b0);

        // extremes row
        row[0]  = pk(127, -128, 127, -128, 127, -128, 127, -128);
        expv[0] = pk(0, 255, 0, 255, 0, 255, 0, 255);
        do_start(1);
        send_row(1);
        drain_all(1, 1'b0);

        // full-length row: beat j lanes = 16*j-128, max 112 -> 240-16*j
        for (int j = 0; j < 16; j++) begin
            row[j]  = uni(16 * j - 128);
            expv[j] = uni(240 - 16 * j);
        end
        do_start(16);
        send_row(16);
        drain_all(16, 1'b0);

        // backpressure: 3 beats, out_ready 0,1,0,0,1,1
        row[0] = pk(1, 2, 3, 4, 5, 6, 7, 8);
        row[1] = uni(-5);
        row[2] = uni(8);
        expv[0] = pk(7, 6, 5, 4, 3, 2, 1, 0);
        expv[1] = uni(13);
        expv[2] = uni(0);
        ready_seq[0] = 4'd0; ready_seq[1] = 4'd1; ready_seq[2] = 4'd0;
        ready_seq[3] = 4'd0; ready_seq[4] = 4'd1; ready_seq[5] = 4'd1;
        do_start(3);
        send_row(3);
        bus.out_ready = 1'b0;
        tick();
        tick();
        hs = 0;
        for (int c = 0; c < 6; c++) begin
            bus.out_ready = ready_seq[c][0];
            chk("bp_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("bp_data",  bus.out_data, expv[hs]);
            chk("bp_last",  {63'd0, bus.out_last}, {63'd0, hs == 2});
            if (ready_seq[c][0]) hs++;
            tick();
        end
        chk("bp_handshakes", 64'(hs), 64'd3);
        chk("bp_valid_end",  {63'd0, bus.out_valid}, 64'd0);
        chk("bp_comp_rst",   {63'd0, comp_rst}, 64'd1);
        tick();
        chk("bp_busy_idle",  {63'd0, busy}, 64'd0);

        // rejected starts
        start = 1'b1; row_len = 5'd0;
        tick();
        start = 1'b0;
        chk("err_len0",  {63'd0, err}, 64'd1);
        chk("busy_len0", {63'd0, busy}, 64'd0);
        tick();
        chk("err_len0_clr", {63'd0, err}, 64'd0);
        start = 1'b1; row_len = 5'd17;
        tick();
        start = 1'b0;
        chk("err_len17",  {63'd0, err}, 64'd1);
        chk("busy_len17", {63'd0, busy}, 64'd0);
        tick();
        chk("err_len17_clr", {63'd0, err}, 64'd0);

        // reset after the 2nd of 4 output beats
        for (int i = 0; i < 4; i++) row[i] = uni(10 * i - 20);
        do_start(4);
        send_row(4);
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("pre_rst_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("pre_rst_data",  bus.out_data, uni(10));
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        one_beat_row();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
